// File: rtl/magic_adder_reg.sv
// Registered 3-bit adder for operands in plain binary or reflected Gray code, selected per transaction.
// Define MAGIC_ADDER_PIPE_EN to add an input register stage (latency 2 instead of 1).
module magic_adder_reg #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_gray,
    output logic             out_valid,
    output logic [WIDTH:0]   sum
);

    logic             stg_valid;
    logic [WIDTH-1:0] stg_a;
    logic [WIDTH-1:0] stg_b;
    logic             stg_gray;

`ifdef MAGIC_ADDER_PIPE_EN
    logic             in_valid_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             is_gray_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_valid_reg <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            is_gray_reg  <= 1'b0;
        end else begin
            in_valid_reg <= in_valid;
            a_reg        <= a;
            b_reg        <= b;
            is_gray_reg  <= is_gray;
        end
    end

    assign stg_valid = in_valid_reg;
    assign stg_a     = a_reg;
    assign stg_b     = b_reg;
    assign stg_gray  = is_gray_reg;
`else
    assign stg_valid = in_valid;
    assign stg_a     = a;
    assign stg_b     = b;
    assign stg_gray  = is_gray;
`endif

    // Gray decode as a prefix XOR: each binary bit is the parity of all Gray bits at or above it.
    logic [WIDTH-1:0] a_bin;
    logic [WIDTH-1:0] b_bin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
            assign a_bin[gi] = ^stg_a[WIDTH-1:gi];
            assign b_bin[gi] = ^stg_b[WIDTH-1:gi];
        end
    endgenerate

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   raw_sum;
    logic [WIDTH:0]   sum_next;

    always_comb begin
        op_a     = stg_gray ? a_bin : stg_a;
        op_b     = stg_gray ? b_bin : stg_b;
        raw_sum  = {1'b0, op_a} + {1'b0, op_b};
        sum_next = stg_gray ? (raw_sum ^ (raw_sum >> 1)) : raw_sum;
    end

    logic [WIDTH:0] sum_reg;
    logic           out_valid_reg;

    // Sum holds its last value across idle cycles; only out_valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= stg_valid;
            if (stg_valid) begin
                sum_reg <= sum_next;
            end
        end
    end

    assign sum       = sum_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_magic_adder_reg.sv
// Self-checking bench for magic_adder_reg: directed spec vectors plus random traffic against a queue-based model.
// Build with MAGIC_ADDER_PIPE_EN defined to check the two-cycle-latency variant.
module tb_magic_adder_reg;

`ifdef MAGIC_ADDER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] a;
    logic [2:0] b;
    logic       is_gray;
    logic       out_valid;
    logic [3:0] sum;

    int errors = 0;
    int checks = 0;

    // Model state: results still in flight, and what the outputs should show now.
    bit         pipe_v[$];
    logic [3:0] pipe_s[$];
    logic       exp_ov;
    logic [3:0] exp_sum;

    magic_adder_reg #(.WIDTH(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .is_gray  (is_gray),
        .out_valid(out_valid),
        .sum      (sum)
    );

    always #5 clk = ~clk;

    function automatic int gray_to_int(input logic [2:0] g);
        for (int n = 0; n < 8; n++) begin
            if (((n ^ (n >> 1)) & 7) == int'(g)) return n;
        end
        return 0;
    endfunction

    function automatic logic [3:0] model_sum(input logic [2:0] ma, input logic [2:0] mb, input logic mg);
        int total;
        if (mg) begin
            total = gray_to_int(ma) + gray_to_int(mb);
            return 4'(total ^ (total >> 1));
        end
        total = int'(ma) + int'(mb);
        return 4'(total);
    endfunction

    task automatic model_reset();
        pipe_v.delete();
        pipe_s.delete();
        for (int i = 0; i < LAT - 1; i++) begin
            pipe_v.push_back(1'b0);
            pipe_s.push_back(4'd0);
        end
        exp_ov  = 1'b0;
        exp_sum = 4'd0;
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (out_valid === exp_ov) else begin
            errors++;
            $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_ov);
        end
        checks++;
        assert (sum === exp_sum) else begin
            errors++;
            $error("FAIL %s sum: got %b expected %b", tag, sum, exp_sum);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check just after it.
    task automatic step(input logic v, input logic [2:0] ta, input logic [2:0] tb_in,
                        input logic tg, input logic trst, input string tag);
        bit         pv;
        logic [3:0] ps;
        in_valid = v;
        a        = ta;
        b        = tb_in;
        is_gray  = tg;
        rst_n    = trst;
        @(posedge clk);
        if (!trst) begin
            model_reset();
        end else begin
            pipe_v.push_back(v);
            pipe_s.push_back(model_sum(ta, tb_in, tg));
            pv = pipe_v.pop_front();
            ps = pipe_s.pop_front();
            exp_ov = pv;
            if (pv) exp_sum = ps;
        end
        #1;
        check_outputs(tag);
        $display("step %-10s rst_n=%b v=%b a=%b b=%b g=%b -> out_valid=%b sum=%b",
                 tag, trst, v, ta, tb_in, tg, out_valid, sum);
    endtask

    // Send one transaction, wait out the latency, then compare against the spec's literal result.
    task automatic directed(input logic [2:0] ta, input logic [2:0] tb_in, input logic tg,
                            input logic [3:0] want, input string tag);
        step(1'b1, ta, tb_in, tg, 1'b1, tag);
        for (int i = 0; i < LAT - 1; i++) step(1'b0, 3'd0, 3'd0, 1'b0, 1'b1, tag);
        checks++;
        assert (sum === want && out_valid === 1'b1) else begin
            errors++;
            $error("FAIL %s literal: got sum=%b ov=%b expected sum=%b ov=1", tag, sum, out_valid, want);
        end
    endtask

    initial begin
        logic [3:0] held;
        model_reset();
        step(1'b1, 3'd5, 3'd6, 1'b0, 1'b0, "reset0");
        step(1'b1, 3'd7, 3'd7, 1'b1, 1'b0, "reset1");
        checks++;
        assert (sum === 4'd0 && out_valid === 1'b0) else begin
            errors++;
            $error("FAIL reset_state: got sum=%b ov=%b expected sum=0000 ov=0", sum, out_valid);
        end
        step(1'b0, 3'd0, 3'd0, 1'b0, 1'b1, "idle");

        directed(3'b001, 3'b010, 1'b0, 4'b0011, "bin_1p2");
        directed(3'b101, 3'b011, 1'b1, 4'b1100, "gray_6p2");
        directed(3'b111, 3'b111, 1'b0, 4'b1110, "bin_max");
        directed(3'b111, 3'b001, 1'b0, 4'b1000, "bin_7p1");
        directed(3'b111, 3'b111, 1'b1, 4'b1111, "gray_max");
        directed(3'b000, 3'b111, 1'b1, 4'b0111, "gray_0p5");

        // Back-to-back with the mode toggling every cycle, then idle to confirm sum holds.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'(i & 1), 1'b1, "toggle");
        end
        step(1'b0, 3'd3, 3'd4, 1'b0, 1'b1, "drain");
        held = sum;
        for (int i = 0; i < 3; i++) step(1'b0, 3'd1, 3'd6, 1'b1, 1'b1, "hold");
        checks++;
        assert (sum === held && out_valid === 1'b0) else begin
            errors++;
            $error("FAIL hold: got sum=%b ov=%b expected sum=%b ov=0", sum, out_valid, held);
        end

        // Reset in the middle of a stream discards in-flight results.
        for (int i = 0; i < 4; i++) step(1'b1, 3'd6, 3'd5, 1'(i & 1), 1'b1, "stream");
        step(1'b1, 3'd7, 3'd2, 1'b0, 1'b0, "midrst");
        checks++;
        assert (sum === 4'd0 && out_valid === 1'b0) else begin
            errors++;
            $error("FAIL midrst: got sum=%b ov=%b expected sum=0000 ov=0", sum, out_valid);
        end
        directed(3'b011, 3'b100, 1'b0, 4'b0111, "post_rst");

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom), 1'($urandom),
                 1'($urandom_range(0, 39) != 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
